// File: rtl/dm_hart_run_ctrl_if.sv
// Run-control bundle between the DMI register block, this controller and the hart debug unit.
interface dm_hart_run_ctrl_if #(
  parameter int unsigned STEP_CNT_W = 16
);
  logic                  cmd_valid_i;
  logic [1:0]            cmd_i;
  logic                  cmd_ready_o;
  logic                  clr_err_i;
  logic                  halt_req_o;
  logic                  dcsr_step_o;
  logic                  dcsr_ebreakm_o;
  logic                  halt_ack_i;
  logic                  resume_ack_i;
  logic                  step_exec_i;
  logic                  ebreak_i;
  logic                  halted_o;
  logic                  running_o;
  logic                  resumeack_o;
  logic                  ebreak_hit_o;
  logic                  cmd_err_o;
  logic                  timeout_err_o;
  logic [STEP_CNT_W-1:0] step_cnt_o;

  // Controller side
  modport slave (
    input  cmd_valid_i, cmd_i, clr_err_i, halt_ack_i, resume_ack_i, step_exec_i, ebreak_i,
    output cmd_ready_o, halt_req_o, dcsr_step_o, dcsr_ebreakm_o, halted_o, running_o,
           resumeack_o, ebreak_hit_o, cmd_err_o, timeout_err_o, step_cnt_o
  );

  // DMI / hart side
  modport master (
    output cmd_valid_i, cmd_i, clr_err_i, halt_ack_i, resume_ack_i, step_exec_i, ebreak_i,
    input  cmd_ready_o, halt_req_o, dcsr_step_o, dcsr_ebreakm_o, halted_o, running_o,
           resumeack_o, ebreak_hit_o, cmd_err_o, timeout_err_o, step_cnt_o
  );
endinterface

// File: rtl/dm_hart_run_ctrl.sv
// Debug-Module run-control initiator for one hart: turns DMI run commands into halt_req and
// dcsr step/ebreakm levels, tracks hart acknowledges, and reports status, sticky errors and steps.
module dm_hart_run_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned STEP_CNT_W  = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  dm_hart_run_ctrl_if.slave bus
);

  localparam int unsigned    TMR_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    CMD_HALT       = 2'b00,
    CMD_RESUME     = 2'b01,
    CMD_STEP       = 2'b10,
    CMD_EBREAK_ARM = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_RUNNING   = 3'd0,
    ST_HALTING   = 3'd1,
    ST_HALTED    = 3'd2,
    ST_RESUMING  = 3'd3,
    ST_STEPPING  = 3'd4,
    ST_EB_ARM    = 3'd5,
    ST_EB_RUN    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  resumeack_q, resumeack_d;
  logic                  ebreak_hit_q, ebreak_hit_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  cmd_e cmd_c;
  logic cmd_ready_c;
  logic cmd_acc_c;
  logic tmr_active_c;
  logic tmr_fire_c;
  logic err_set_c;
  logic to_set_c;

  assign cmd_c        = cmd_e'(bus.cmd_i);
  assign cmd_ready_c  = (state_q == ST_RUNNING) || (state_q == ST_HALTED) || (state_q == ST_EB_RUN);
  assign cmd_acc_c    = bus.cmd_valid_i && cmd_ready_c;
  assign tmr_active_c = (state_q == ST_HALTING) || (state_q == ST_RESUMING) || (state_q == ST_STEPPING);
  assign tmr_fire_c   = tmr_active_c && (tmr_q == TMR_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= ST_RUNNING;
      tmr_q         <= '0;
      resumeack_q   <= 1'b0;
      ebreak_hit_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      resumeack_q   <= resumeack_d;
      ebreak_hit_q  <= ebreak_hit_d;
      cmd_err_q     <= cmd_err_d;
      timeout_err_q <= timeout_err_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  // Next state; acknowledges are tested before the timeout so an ack on the last cycle wins
  always_comb begin
    state_d      = state_q;
    resumeack_d  = resumeack_q;
    ebreak_hit_d = 1'b0;
    step_cnt_d   = step_cnt_q;
    err_set_c    = 1'b0;
    to_set_c     = 1'b0;

    unique case (state_q)
      ST_RUNNING: begin
        if (cmd_acc_c) begin
          if (cmd_c == CMD_HALT) state_d = ST_HALTING;
          else                   err_set_c = 1'b1;
        end
      end
      ST_HALTING: begin
        if (bus.halt_ack_i) begin
          state_d = ST_HALTED;
        end else if (tmr_fire_c) begin
          state_d  = ST_RUNNING;
          to_set_c = 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_c) begin
          unique case (cmd_c)
            CMD_HALT:       state_d = ST_HALTED;
            CMD_RESUME:     state_d = ST_RESUMING;
            CMD_STEP:       state_d = ST_STEPPING;
            CMD_EBREAK_ARM: state_d = ST_EB_ARM;
          endcase
          if (cmd_c != CMD_HALT) resumeack_d = 1'b0;
        end
      end
      ST_RESUMING: begin
        if (bus.resume_ack_i) begin
          state_d     = ST_RUNNING;
          resumeack_d = 1'b1;
        end else if (tmr_fire_c) begin
          state_d  = ST_RUNNING;
          to_set_c = 1'b1;
        end
      end
      ST_STEPPING: begin
        if (bus.step_exec_i && bus.halt_ack_i) begin
          state_d    = ST_HALTED;
          step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
        end else if (tmr_fire_c) begin
          to_set_c = 1'b1;
        end
      end
      ST_EB_ARM: begin
        state_d = ST_EB_RUN;
      end
      ST_EB_RUN: begin
        if (bus.resume_ack_i) resumeack_d = 1'b1;
        // Breakpoint halt takes precedence over a same-cycle HALT command
        if (bus.ebreak_i && bus.halt_ack_i) begin
          state_d      = ST_HALTED;
          ebreak_hit_d = 1'b1;
        end else if (cmd_acc_c) begin
          if (cmd_c == CMD_HALT) state_d = ST_HALTING;
          else                   err_set_c = 1'b1;
        end
      end
      default: state_d = ST_RUNNING;
    endcase

    cmd_err_d     = bus.clr_err_i ? 1'b0 : (cmd_err_q || err_set_c);
    timeout_err_d = bus.clr_err_i ? 1'b0 : (timeout_err_q || to_set_c);

    // Ack timer restarts on every state change and saturates at its last count
    if ((state_d != state_q) || !tmr_active_c) tmr_d = '0;
    else if (tmr_q == TMR_LAST)                tmr_d = tmr_q;
    else                                       tmr_d = tmr_q + TMR_W'(1);
  end

  assign bus.cmd_ready_o    = cmd_ready_c;
  assign bus.halt_req_o     = (state_q == ST_HALTING) || (state_q == ST_HALTED) ||
                              (state_q == ST_STEPPING) || (state_q == ST_EB_ARM);
  assign bus.dcsr_step_o    = (state_q == ST_STEPPING);
  assign bus.dcsr_ebreakm_o = (state_q == ST_EB_ARM) || (state_q == ST_EB_RUN);
  assign bus.halted_o       = (state_q == ST_HALTED);
  assign bus.running_o      = (state_q == ST_RUNNING) || (state_q == ST_EB_RUN);
  assign bus.resumeack_o    = resumeack_q;
  assign bus.ebreak_hit_o   = ebreak_hit_q;
  assign bus.cmd_err_o      = cmd_err_q;
  assign bus.timeout_err_o  = timeout_err_q;
  assign bus.step_cnt_o     = step_cnt_q;

endmodule

// File: tb/tb_dm_hart_run_ctrl.sv
// Directed bench for dm_hart_run_ctrl with ACK_TIMEOUT=4.
// Status vector: {halt_req, step, ebreakm, halted, running, ready, resumeack, ebreak_hit, cmd_err, timeout_err}
module tb_dm_hart_run_ctrl;

  localparam logic [1:0] C_HALT   = 2'b00;
  localparam logic [1:0] C_RESUME = 2'b01;
  localparam logic [1:0] C_STEP   = 2'b10;
  localparam logic [1:0] C_EBARM  = 2'b11;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [9:0] outs;

  dm_hart_run_ctrl_if #(.STEP_CNT_W(16)) bus ();

  dm_hart_run_ctrl #(
    .ACK_TIMEOUT (4),
    .STEP_CNT_W  (16)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  assign outs = {bus.halt_req_o, bus.dcsr_step_o, bus.dcsr_ebreakm_o, bus.halted_o,
                 bus.running_o, bus.cmd_ready_o, bus.resumeack_o, bus.ebreak_hit_o,
                 bus.cmd_err_o, bus.timeout_err_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic clr();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; n_checks = 0; n_errors = 0;
    bus.cmd_valid_i = 1'b0; bus.cmd_i = 2'b00; bus.clr_err_i = 1'b0;
    bus.halt_ack_i = 1'b0; bus.resume_ack_i = 1'b0; bus.step_exec_i = 1'b0; bus.ebreak_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'(10'b0000110000));
    check("reset_cnt", 32'(bus.step_cnt_o), 32'd0);
    reset_n = 1'b1;
    tick();
    check("run_idle", 32'(outs), 32'(10'b0000110000));

    // HALT, hart acks three cycles later
    send(C_HALT);
    check("halting_c1", 32'(outs), 32'(10'b1000000000));
    tick(); tick();
    check("halting_c3", 32'(outs), 32'(10'b1000000000));
    bus.halt_ack_i = 1'b1;
    tick();
    check("halted_c4", 32'(outs), 32'(10'b1001010000));

    // RESUME, ack on the second cycle
    bus.halt_ack_i = 1'b0;
    send(C_RESUME);
    check("resuming", 32'(outs), 32'(10'b0000000000));
    tick();
    bus.resume_ack_i = 1'b1;
    tick();
    bus.resume_ack_i = 1'b0;
    check("resumed", 32'(outs), 32'(10'b0000111000));

    // illegal command in RUNNING, clear, clear beating a same-cycle error
    send(C_RESUME);
    check("cmd_err_run", 32'(outs), 32'(10'b0000111010));
    clr();
    check("clr_cmd_err", 32'(outs), 32'(10'b0000111000));
    bus.clr_err_i = 1'b1;
    send(C_STEP);
    bus.clr_err_i = 1'b0;
    check("clr_prio", 32'(outs), 32'(10'b0000111000));

    // HALT with ack arriving on the cycle the timeout would fire
    send(C_HALT);
    tick(); tick(); tick();
    check("halting_last", 32'(outs), 32'(10'b1000001000));
    bus.halt_ack_i = 1'b1;
    tick();
    check("ack_beats_to", 32'(outs), 32'(10'b1001011000));
    send(C_HALT);
    check("halt_in_halted", 32'(outs), 32'(10'b1001011000));

    // three single steps
    for (int i = 0; i < 3; i++) begin
      bus.halt_ack_i = 1'b0;
      send(C_STEP);
      check("stepping", 32'(outs), 32'(10'b1100000000));
      bus.step_exec_i = 1'b1;
      tick(); tick();
      bus.halt_ack_i = 1'b1;
      tick();
      bus.step_exec_i = 1'b0;
      check("step_done", 32'(outs), 32'(10'b1001010000));
      check("step_cnt", 32'(bus.step_cnt_o), 32'(i + 1));
    end

    // step timeout keeps the state
    bus.halt_ack_i = 1'b0;
    send(C_STEP);
    tick(); tick(); tick();
    check("step_pre_to", 32'(outs), 32'(10'b1100000000));
    tick();
    check("step_to_hold", 32'(outs), 32'(10'b1100000001));
    bus.step_exec_i = 1'b1;
    bus.halt_ack_i  = 1'b1;
    tick();
    bus.step_exec_i = 1'b0;
    check("step_late", 32'(outs), 32'(10'b1001010001));
    check("step_cnt4", 32'(bus.step_cnt_o), 32'd4);
    clr();
    check("clr_to_err", 32'(outs), 32'(10'b1001010000));

    // breakpoint arm and hit, with a HALT on the same cycle
    bus.halt_ack_i = 1'b0;
    send(C_EBARM);
    check("eb_arm", 32'(outs), 32'(10'b1010000000));
    tick();
    check("eb_run", 32'(outs), 32'(10'b0010110000));
    bus.resume_ack_i = 1'b1;
    tick();
    bus.resume_ack_i = 1'b0;
    check("eb_resack", 32'(outs), 32'(10'b0010111000));
    send(C_STEP);
    check("eb_bad_cmd", 32'(outs), 32'(10'b0010111010));
    clr();
    repeat (6) tick();
    bus.ebreak_i   = 1'b1;
    bus.halt_ack_i = 1'b1;
    send(C_HALT);
    bus.ebreak_i = 1'b0;
    check("eb_hit", 32'(outs), 32'(10'b1001011100));
    tick();
    check("eb_hit_pulse", 32'(outs), 32'(10'b1001011000));

    // HALT from EB_RUN drops ebreakm
    bus.halt_ack_i = 1'b0;
    send(C_EBARM);
    tick();
    send(C_HALT);
    check("eb_halt", 32'(outs), 32'(10'b1000000000));
    bus.halt_ack_i = 1'b1;
    tick();
    check("eb_halted", 32'(outs), 32'(10'b1001010000));

    // HALT timeout from RUNNING
    bus.halt_ack_i = 1'b0;
    send(C_RESUME);
    bus.resume_ack_i = 1'b1;
    tick();
    bus.resume_ack_i = 1'b0;
    check("run_again", 32'(outs), 32'(10'b0000111000));
    send(C_HALT);
    tick(); tick(); tick();
    check("to_pre", 32'(outs), 32'(10'b1000001000));
    tick();
    check("to_fire", 32'(outs), 32'(10'b0000111001));
    clr();
    check("to_clr", 32'(outs), 32'(10'b0000111000));

    // asynchronous reset while stepping
    send(C_HALT);
    bus.halt_ack_i = 1'b1;
    tick();
    check("pre_rst_halt", 32'(outs), 32'(10'b1001011000));
    bus.halt_ack_i = 1'b0;
    send(C_STEP);
    check("pre_rst_step", 32'(outs), 32'(10'b1100000000));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst", 32'(outs), 32'(10'b0000110000));
    check("async_rst_cnt", 32'(bus.step_cnt_o), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("post_rst", 32'(outs), 32'(10'b0000110000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
